// File: rtl/mdu_pkg.sv
// mdu_pkg: shared constants and types for the iterative multiply/divide unit.
//   - WIDTH / MDU_ITERS / CNT_W : datapath width, iteration count, counter width
//   - MDU_* opcodes             : op encodings on mult_div_unit.op
//   - mdu_state_e               : IDLE/RUN/FIN control states
//   - mdu_result_t              : {hi, lo} result payload
package mdu_pkg;

    localparam int unsigned WIDTH     = 32;
    localparam int unsigned MDU_ITERS = 32;
    localparam int unsigned CNT_W     = 5;

    localparam logic [1:0] MDU_MULT  = 2'b00;
    localparam logic [1:0] MDU_MULTU = 2'b01;
    localparam logic [1:0] MDU_DIV   = 2'b10;
    localparam logic [1:0] MDU_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } mdu_state_e;

    typedef struct packed {
        logic [WIDTH-1:0] hi;
        logic [WIDTH-1:0] lo;
    } mdu_result_t;

endpackage

// File: rtl/mdu_sign_fix.sv
// mdu_sign_fix: combinational sign handling for signed MULT/DIV.
// Only instantiated when MDU_SIGNED_EN is defined.
//   signed_i             : operation is signed (MULT/DIV)
//   rs_i / rt_i          : raw operands
//   mag_a_c_o/mag_b_c_o  : operand magnitudes
//   neg_a_c_o/neg_b_c_o  : operand sign flags (0 for unsigned ops)
//   is_div_i             : result is {remainder, quotient} rather than a product
//   neg_lo_i / neg_hi_i  : negate product/quotient, negate remainder
//   res_i / res_c_o      : unsigned result in, sign-corrected result out
module mdu_sign_fix
    import mdu_pkg::*;
(
    input  logic             signed_i,
    input  logic [WIDTH-1:0] rs_i,
    input  logic [WIDTH-1:0] rt_i,
    output logic [WIDTH-1:0] mag_a_c_o,
    output logic [WIDTH-1:0] mag_b_c_o,
    output logic             neg_a_c_o,
    output logic             neg_b_c_o,
    input  logic             is_div_i,
    input  logic             neg_lo_i,
    input  logic             neg_hi_i,
    input  mdu_result_t      res_i,
    output mdu_result_t      res_c_o
);

    logic [2*WIDTH-1:0] prod_neg;

    // Operand conditioning; -32'h80000000 wraps to itself, which is the correct magnitude
    assign neg_a_c_o = signed_i & rs_i[WIDTH-1];
    assign neg_b_c_o = signed_i & rt_i[WIDTH-1];
    assign mag_a_c_o = neg_a_c_o ? (~rs_i + WIDTH'(1)) : rs_i;
    assign mag_b_c_o = neg_b_c_o ? (~rt_i + WIDTH'(1)) : rt_i;

    assign prod_neg = ~res_i + (2*WIDTH)'(1);

    // Result fixup: whole 64-bit product, or quotient and remainder independently
    always_comb begin
        res_c_o = res_i;
        if (!is_div_i) begin
            if (neg_lo_i) begin
                res_c_o = mdu_result_t'(prod_neg);
            end
        end else begin
            if (neg_lo_i) begin
                res_c_o.lo = ~res_i.lo + WIDTH'(1);
            end
            if (neg_hi_i) begin
                res_c_o.hi = ~res_i.hi + WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative radix-2 multiply/divide with architectural HI/LO.
// Executes MULT/MULTU/DIV/DIVU in 33 cycles after the accepting edge
// (32 iterations + 1 commit). MTHI/MTLO writes are honoured only when idle.
// Define MDU_SIGNED_EN to enable signed MULT/DIV; otherwise they run unsigned.
//   clk, reset           : clock, synchronous active-high reset
//   start, op            : launch request and opcode (sampled on accept only)
//   rsData, rtData       : operand A (multiplicand/dividend), operand B
//   hiWrite, loWrite     : MTHI / MTLO strobes with writeData
//   busy, done           : operation in flight, one-cycle result pulse
//   hi, lo               : HI/LO registers
module mult_div_unit
    import mdu_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rsData,
    input  logic [WIDTH-1:0] rtData,
    input  logic             hiWrite,
    input  logic             loWrite,
    input  logic [WIDTH-1:0] writeData,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    mdu_state_e          state_q, state_d;
    logic [2*WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]    opb_q, opb_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                div_q, div_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [WIDTH-1:0]    hi_q, hi_d;
    logic [WIDTH-1:0]    lo_q, lo_d;

    logic [WIDTH-1:0]    mag_a, mag_b;
    mdu_result_t         res_fix;
    logic                op_is_div;

    logic [WIDTH:0]      mul_sum;
    logic [2*WIDTH-1:0]  mul_step;
    logic [WIDTH:0]      rem_sh;
    logic [WIDTH:0]      rem_diff;
    logic [2*WIDTH-1:0]  div_step;

    assign op_is_div = (op == MDU_DIV) || (op == MDU_DIVU);

`ifdef MDU_SIGNED_EN
    logic neg_a, neg_b;
    logic neg_lo_q, neg_lo_d;
    logic neg_hi_q, neg_hi_d;

    mdu_sign_fix u_sign_fix (
        .signed_i  ((op == MDU_MULT) || (op == MDU_DIV)),
        .rs_i      (rsData),
        .rt_i      (rtData),
        .mag_a_c_o (mag_a),
        .mag_b_c_o (mag_b),
        .neg_a_c_o (neg_a),
        .neg_b_c_o (neg_b),
        .is_div_i  (div_q),
        .neg_lo_i  (neg_lo_q),
        .neg_hi_i  (neg_hi_q),
        .res_i     (mdu_result_t'(acc_q)),
        .res_c_o   (res_fix)
    );
`else
    assign mag_a   = rsData;
    assign mag_b   = rtData;
    assign res_fix = mdu_result_t'(acc_q);
`endif

    // Multiply step: conditional add into the upper half, then shift {acc, multiplier} right
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : (WIDTH+1)'(0));
    assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring divide step: shift next dividend bit into the remainder, subtract if it fits
    assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign rem_diff = rem_sh - {1'b0, opb_q};
    assign div_step = rem_diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                      : {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        opb_d   = opb_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
`ifdef MDU_SIGNED_EN
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (hiWrite) begin
                    hi_d = writeData;
                end
                if (loWrite) begin
                    lo_d = writeData;
                end
                if (start) begin
                    div_d   = op_is_div;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                    // Divide: {remainder=0, dividend}; multiply: {acc=0, multiplier}
                    acc_d   = op_is_div ? {WIDTH'(0), mag_a} : {WIDTH'(0), mag_b};
                    opb_d   = op_is_div ? mag_b : mag_a;
`ifdef MDU_SIGNED_EN
                    // Divide by zero keeps the all-ones quotient unnegated
                    neg_lo_d = (neg_a ^ neg_b) & (!op_is_div || (rtData != '0));
                    neg_hi_d = op_is_div & neg_a;
`endif
                end
            end
            RUN: begin
                acc_d = div_q ? div_step : mul_step;
                if (cnt_q == CNT_W'(MDU_ITERS - 1)) begin
                    state_d = FIN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            FIN: begin
                hi_d    = res_fix.hi;
                lo_d    = res_fix.lo;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            opb_q   <= '0;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
`ifdef MDU_SIGNED_EN
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
`ifdef MDU_SIGNED_EN
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed bench for mult_div_unit with a transaction-level
// reference model (plain integer arithmetic + latency countdown) compared on
// every cycle, plus hand-computed literal results per operation.
// Honours MDU_SIGNED_EN the same way as the design.
module tb_mult_div_unit;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rsData, rtData;
    logic        hiWrite, loWrite;
    logic [31:0] writeData;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    mult_div_unit dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .rsData    (rsData),
        .rtData    (rtData),
        .hiWrite   (hiWrite),
        .loWrite   (loWrite),
        .writeData (writeData),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the ISA definition
    function automatic void compute(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] h, output logic [31:0] l);
        longint sa, sb, q, r;
        logic [63:0] p;
        bit sgn;
        sgn = (o == MDU_MULT) || (o == MDU_DIV);
`ifndef MDU_SIGNED_EN
        sgn = 1'b0;
`endif
        sa = sgn ? longint'($signed(a)) : longint'(a);
        sb = sgn ? longint'($signed(b)) : longint'(b);
        if (o == MDU_MULT || o == MDU_MULTU) begin
            p = 64'(sa * sb);
            h = p[63:32];
            l = p[31:0];
        end else if (b == 32'd0) begin
            l = 32'hFFFF_FFFF;
            h = a;
        end else begin
            q = sa / sb;
            r = sa % sb;
            l = 32'(q);
            h = 32'(r);
        end
    endfunction

    // Model: idle/pending latency countdown; result lands 33 edges after accept
    int          m_left;
    logic        m_busy, m_done;
    logic [31:0] m_hi, m_lo, p_hi, p_lo;

    always @(posedge clk) begin
        if (reset) begin
            m_left = 0; m_busy = 0; m_done = 0; m_hi = 0; m_lo = 0;
        end else begin
            m_done = 0;
            if (m_left == 0) begin
                if (hiWrite) m_hi = writeData;
                if (loWrite) m_lo = writeData;
                if (start) begin
                    compute(op, rsData, rtData, p_hi, p_lo);
                    m_left = 33;
                    m_busy = 1;
                end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_hi = p_hi; m_lo = p_lo; m_done = 1; m_busy = 0;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_busy", 64'(busy), 64'(m_busy));
            chk("cyc_done", 64'(done), 64'(m_done));
            chk("cyc_hi", 64'(hi), 64'(m_hi));
            chk("cyc_lo", 64'(lo), 64'(m_lo));
        end
    end

    task automatic wait_done(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Launch one op, scramble inputs afterwards, check latency and literal result
    task automatic do_op(input string nm, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input bit now);
        int n;
        if (!now) @(negedge clk);
        start = 1; op = o; rsData = a; rtData = b;
        @(negedge clk);
        start = 0; op = 2'($urandom); rsData = $urandom; rtData = $urandom;
        wait_done(n);
        chk({nm, "_lat"}, 64'(n), 64'd33);
        chk({nm, "_done"}, 64'(done), 64'd1);
        chk({nm, "_hi"}, 64'(hi), 64'(eh));
        chk({nm, "_lo"}, 64'(lo), 64'(el));
    endtask

    initial begin
        int n;
        reset = 1; start = 0; op = 0; rsData = 0; rtData = 0;
        hiWrite = 0; loWrite = 0; writeData = 0;
        @(posedge clk);
        chk_en = 1;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        reset = 0;

        do_op("multu_max", MDU_MULTU, 32'hFFFF_FFFF, 32'h2, 32'h1, 32'hFFFF_FFFE, 0);
        @(negedge clk);
        chk("done_one_cycle", 64'(done), 64'd0);
`ifdef MDU_SIGNED_EN
        do_op("mult_neg", MDU_MULT, -32'sd3, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
        do_op("mult_nn", MDU_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 0);
        do_op("div_neg", MDU_DIV, -32'sd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        do_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 0);
`else
        do_op("mult_neg", MDU_MULT, -32'sd3, 32'd7, 32'h6, 32'hFFFF_FFEB, 0);
        do_op("mult_nn", MDU_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 0);
        do_op("div_neg", MDU_DIV, -32'sd7, 32'd2, 32'h1, 32'h7FFF_FFFC, 0);
        do_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 0);
`endif
        do_op("divu_zero", MDU_DIVU, 32'd100, 32'd0, 32'h64, 32'hFFFF_FFFF, 0);
        do_op("div_zero", MDU_DIV, -32'sd5, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 0);
        // Accept on the same cycle done is high
        do_op("b2b_mulu", MDU_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h1, 32'h0, 1);

        // MTHI in idle
        @(negedge clk);
        hiWrite = 1; writeData = 32'hA5A5_A5A5;
        @(negedge clk);
        hiWrite = 0;
        chk("mthi", 64'(hi), 64'hA5A5_A5A5);

        // MTLO on the accepting edge lands, then the result overwrites it
        @(negedge clk);
        loWrite = 1; writeData = 32'h1234_5678;
        start = 1; op = MDU_MULTU; rsData = 3; rtData = 5;
        @(negedge clk);
        start = 0; loWrite = 0;
        chk("mtlo_with_start", 64'(lo), 64'h1234_5678);
        wait_done(n);
        chk("mtlo_then_res_hi", 64'(hi), 64'h0);
        chk("mtlo_then_res_lo", 64'(lo), 64'hF);

        // Second start and MTLO while busy are ignored
        @(negedge clk);
        start = 1; op = MDU_DIVU; rsData = 1000; rtData = 7;
        @(negedge clk);
        start = 0;
        repeat (5) @(negedge clk);
        start = 1; op = MDU_MULTU; rsData = 9; rtData = 9; loWrite = 1; writeData = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 0; loWrite = 0;
        wait_done(n);
        chk("busy_ign_done", 64'(done), 64'd1);
        chk("busy_ign_hi", 64'(hi), 64'd6);
        chk("busy_ign_lo", 64'(lo), 64'd142);
        @(negedge clk);
        chk("busy_ign_idle", 64'(busy), 64'd0);

        // Reset during iteration 10 of a DIVU
        start = 1; op = MDU_DIVU; rsData = 32'hFFFF_0000; rtData = 3;
        @(negedge clk);
        start = 0;
        repeat (10) @(negedge clk);
        reset = 1;
        @(negedge clk);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_hi", 64'(hi), 64'd0);
        chk("midrst_lo", 64'(lo), 64'd0);
        reset = 0;
        do_op("after_rst", MDU_DIVU, 32'd1000, 32'd7, 32'd6, 32'd142, 0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
